// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path.
//   - Default datapath, opcode-tag and counter widths.
//   - Opcode tags carried alongside results. The result stage does not decode them.
//   - State encoding of the result stage's EMPTY/ONE/FULL occupancy machine.
package alu_pkg;

    localparam int ALU_WIDTH = 64;
    localparam int ALU_OPW   = 3;
    localparam int ALU_CNTW  = 16;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SRA = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag generator for an ALU result.
// Ports:
//   result  in   WIDTH  value to classify
//   zero    out  1      result == 0
//   neg     out  1      result MSB
//   parity  out  1      XOR-reduce of result (1 = odd number of ones)
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             parity
);

    function automatic logic odd_parity(input logic [WIDTH-1:0] value);
        return ^value;
    endfunction

    assign zero   = (result == {WIDTH{1'b0}});
    assign neg    = result[WIDTH-1];
    assign parity = odd_parity(result);

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU function units.
// Captures a result with its opcode and its status flags. The flags are computed
// once on the input path and stored with the entry. The stage then presents the
// entry downstream over valid/ready. A main register drives out_*, and a skid
// register absorbs one extra entry. This keeps in_ready a pure flop output while
// still allowing one transfer per cycle.
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   in_valid/in_ready             upstream handshake (in_ready registered)
//   in_op, in_result              opcode tag and ALU result
//   out_valid/out_ready           downstream handshake
//   out_op, out_result            presented entry
//   out_zero, out_neg, out_parity flags stored with the presented entry
//   result_count                  completed output transfers, modulo 2^CNTW
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW,
    parameter int CNTW  = ALU_CNTW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPW-1:0]   out_op,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_parity,
    output logic [CNTW-1:0]  result_count
);

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    stage_state_e     state_r;
    stage_state_e     state_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [CNTW-1:0]  count_r;

    logic [OPW-1:0]   main_op_r;
    logic [WIDTH-1:0] main_result_r;
    logic             main_zero_r;
    logic             main_neg_r;
    logic             main_parity_r;

    logic [OPW-1:0]   skid_op_r;
    logic [WIDTH-1:0] skid_result_r;
    logic             skid_zero_r;
    logic             skid_neg_r;
    logic             skid_parity_r;

    logic             in_zero_s;
    logic             in_neg_s;
    logic             in_parity_s;
    logic             accept_s;
    logic             retire_s;
    logic             load_main_in_s;
    logic             load_main_skid_s;
    logic             load_skid_s;

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .result (in_result),
        .zero   (in_zero_s),
        .neg    (in_neg_s),
        .parity (in_parity_s)
    );

    assign accept_s = in_valid & in_ready_r;
    assign retire_s = out_valid_r & out_ready;

    // Next-state and register-load selection for the occupancy FSM.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    load_main_in_s = 1'b1;
                    state_nxt_s    = ST_ONE;
                end else begin
                    state_nxt_s    = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && retire_s) begin
                    load_main_in_s = 1'b1;
                    state_nxt_s    = ST_ONE;
                end else if (accept_s) begin
                    load_skid_s    = 1'b1;
                    state_nxt_s    = ST_FULL;
                end else if (retire_s) begin
                    state_nxt_s    = ST_EMPTY;
                end else begin
                    state_nxt_s    = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so no accept can coincide with the retire.
                if (retire_s) begin
                    load_main_skid_s = 1'b1;
                    state_nxt_s      = ST_ONE;
                end else begin
                    state_nxt_s      = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State register plus handshake flags derived from the next state, so both ports come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_FULL);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    // Main entry register: loaded from the input or promoted from the skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_op_r     <= {OPW{1'b0}};
            main_result_r <= {WIDTH{1'b0}};
            main_zero_r   <= 1'b0;
            main_neg_r    <= 1'b0;
            main_parity_r <= 1'b0;
        end else if (load_main_in_s) begin
            main_op_r     <= in_op;
            main_result_r <= in_result;
            main_zero_r   <= in_zero_s;
            main_neg_r    <= in_neg_s;
            main_parity_r <= in_parity_s;
        end else if (load_main_skid_s) begin
            main_op_r     <= skid_op_r;
            main_result_r <= skid_result_r;
            main_zero_r   <= skid_zero_r;
            main_neg_r    <= skid_neg_r;
            main_parity_r <= skid_parity_r;
        end else begin
            main_op_r     <= main_op_r;
            main_result_r <= main_result_r;
            main_zero_r   <= main_zero_r;
            main_neg_r    <= main_neg_r;
            main_parity_r <= main_parity_r;
        end
    end

    // Skid entry register: holds the second entry while the main entry is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_op_r     <= {OPW{1'b0}};
            skid_result_r <= {WIDTH{1'b0}};
            skid_zero_r   <= 1'b0;
            skid_neg_r    <= 1'b0;
            skid_parity_r <= 1'b0;
        end else if (load_skid_s) begin
            skid_op_r     <= in_op;
            skid_result_r <= in_result;
            skid_zero_r   <= in_zero_s;
            skid_neg_r    <= in_neg_s;
            skid_parity_r <= in_parity_s;
        end else begin
            skid_op_r     <= skid_op_r;
            skid_result_r <= skid_result_r;
            skid_zero_r   <= skid_zero_r;
            skid_neg_r    <= skid_neg_r;
            skid_parity_r <= skid_parity_r;
        end
    end

    // Retired-result counter. It wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNTW{1'b0}};
        end else if (retire_s) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_op       = main_op_r;
    assign out_result   = main_result_r;
    assign out_zero     = main_zero_r;
    assign out_neg      = main_neg_r;
    assign out_parity   = main_parity_r;
    assign result_count = count_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage.
// A queue-based model of a two-deep in-order buffer predicts the handshake,
// the presented entry and the counter. It checks them on every falling edge.
// Directed scenarios add literal expectations on top.
module tb_alu_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_result;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [63:0] out_result;
    logic        out_zero;
    logic        out_neg;
    logic        out_parity;
    logic [15:0] result_count;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] res;
    } entry_t;

    entry_t      mq[$];
    logic        m_in_ready = 1'b1;
    logic [15:0] m_count    = 16'd0;
    bit          model_live = 1'b0;

    alu_result_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_result    (in_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_neg      (out_neg),
        .out_parity   (out_parity),
        .result_count (result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a FIFO of at most two entries, updated on each rising edge.
    initial begin
        bit acc;
        bit ret;
        entry_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_in_ready = 1'b1;
                m_count    = 16'd0;
                model_live = 1'b1;
            end else begin
                acc = in_valid && m_in_ready;
                ret = (mq.size() != 0) && out_ready;
                if (ret) begin
                    e = mq.pop_front();
                    m_count = m_count + 16'd1;
                end
                if (acc) begin
                    e.op  = in_op;
                    e.res = in_result;
                    mq.push_back(e);
                end
                m_in_ready = (mq.size() < 2);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("m_in_ready", {63'd0, in_ready}, {63'd0, m_in_ready});
            check("m_out_valid", {63'd0, out_valid}, {63'd0, (mq.size() != 0)});
            check("m_count", {48'd0, result_count}, {48'd0, m_count});
            if (mq.size() != 0) begin
                check("m_out_result", out_result, mq[0].res);
                check("m_out_op", {61'd0, out_op}, {61'd0, mq[0].op});
                check("m_zero", {63'd0, out_zero}, {63'd0, (mq[0].res == 64'd0)});
                check("m_neg", {63'd0, out_neg}, {63'd0, mq[0].res[63]});
                check("m_parity", {63'd0, out_parity}, 64'($countones(mq[0].res) % 2));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_result = 64'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_count", {48'd0, result_count}, 64'd0);
        check("rst_result", out_result, 64'd0);

        // 1: zero result
        in_valid  = 1'b1;
        in_result = 64'h0;
        in_op     = 3'd0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_valid", {63'd0, out_valid}, 64'd1);
        check("t1_zero", {63'd0, out_zero}, 64'd1);
        check("t1_neg", {63'd0, out_neg}, 64'd0);
        check("t1_parity", {63'd0, out_parity}, 64'd0);
        @(negedge clk);
        check("t1_count", {48'd0, result_count}, 64'd1);

        // 2: negative, even parity
        in_valid  = 1'b1;
        in_result = 64'h8000_0000_0000_0001;
        in_op     = 3'd1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_neg", {63'd0, out_neg}, 64'd1);
        check("t2_parity", {63'd0, out_parity}, 64'd0);
        check("t2_zero", {63'd0, out_zero}, 64'd0);
        check("t2_op", {61'd0, out_op}, 64'd1);
        @(negedge clk);

        // 3: backpressure, fill both entries, third push ignored
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd3;
        in_result = 64'h3;
        @(negedge clk);
        in_result = 64'h7;
        @(negedge clk);
        check("t3_in_ready_low", {63'd0, in_ready}, 64'd0);
        in_result = 64'hF;
        repeat (2) @(negedge clk);
        check("t3_hold_result", out_result, 64'h3);
        check("t3_hold_ready", {63'd0, in_ready}, 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t3_first", out_result, 64'h3);
        @(negedge clk);
        check("t3_second", out_result, 64'h7);
        check("t3_second_valid", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        check("t3_drained", {63'd0, out_valid}, 64'd0);
        check("t3_count", {48'd0, result_count}, 64'd4);

        // 4: streaming ten results
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_op     = 3'(i);
            in_result = 64'h1111_1111_1111_1111 * 64'(i + 1);
            @(negedge clk);
            check("t4_in_ready", {63'd0, in_ready}, 64'd1);
            check("t4_order", out_result, 64'h1111_1111_1111_1111 * 64'(i + 1));
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_count", {48'd0, result_count}, 64'd10);

        // 5: reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 64'hA;
        @(negedge clk);
        in_result = 64'hB;
        @(negedge clk);
        check("t5_full", {63'd0, in_ready}, 64'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_valid", {63'd0, out_valid}, 64'd0);
        check("t5_ready", {63'd0, in_ready}, 64'd1);
        check("t5_count", {48'd0, result_count}, 64'd0);
        check("t5_result", out_result, 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_stale", {63'd0, out_valid}, 64'd0);
        end

        // 6: counter wrap
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_valid  = 1'b1;
            in_op     = 3'(i);
            in_result = 64'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_max", {48'd0, result_count}, 64'hFFFF);
        in_valid  = 1'b1;
        in_result = 64'h5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_wrap", {48'd0, result_count}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
